// File: rtl/lut_layer_sequencer_if.sv
// Handshake and configuration bundle for lut_layer_sequencer: input vector,
// result vector and the table/connection write port.
interface lut_layer_sequencer_if #(
  parameter int N_NEURONS = 16,
  parameter int IN_WIDTH  = 64,
  parameter int FAN_IN    = 8,
  parameter int IDX_W     = $clog2(IN_WIDTH),
  parameter int NID_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_NEURONS-1:0] out_data;
  logic                 cfg_we;
  logic                 cfg_sel;
  logic [NID_W-1:0]     cfg_nid;
  logic [FAN_IN-1:0]    cfg_addr;
  logic [IDX_W-1:0]     cfg_data;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_nid, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_nid, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lut_layer_sequencer.sv
// Serial evaluator for one layer of 1-bit LUT neurons held in runtime-loaded RAM.
// Optional macro LUT_LAYER_SEQUENCER_PERF_EN adds a saturating perf_vectors counter.
module lut_layer_sequencer #(
  parameter int N_NEURONS = 16,
  parameter int IN_WIDTH  = 64,
  parameter int FAN_IN    = 8,
  parameter int IDX_W     = $clog2(IN_WIDTH),
  parameter int NID_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic clk,
  input  logic rst,
  lut_layer_sequencer_if.slave bus,
  output logic busy
`ifdef LUT_LAYER_SEQUENCER_PERF_EN
  ,
  output logic [31:0] perf_vectors
`endif
);

  localparam int TBL_N  = 1 << FAN_IN;
  localparam int SLOT_W = (FAN_IN > 1) ? $clog2(FAN_IN) : 1;
  localparam logic [NID_W-1:0] LAST_NID = NID_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t               state_q, state_d;
  logic                 accept;
  logic                 cfg_en;
  logic                 last_b;
  logic                 run_a;
  logic [NID_W-1:0]     nid;
  logic [IN_WIDTH-1:0]  x_reg;
  logic [N_NEURONS-1:0] res_q;

  logic [FAN_IN-1:0]    addr_p0;
  logic [FAN_IN-1:0]    addr_p1;
  logic [NID_W-1:0]     nid_p1;
  logic                 vld_p1;

  logic [TBL_N-1:0]     tbl_mem  [N_NEURONS];
  logic [IDX_W-1:0]     conn_mem [N_NEURONS][FAN_IN];

  // Out-of-range connection indices read as a constant 0 input.
  function automatic logic pick_bit(input logic [IN_WIDTH-1:0] x, input logic [IDX_W-1:0] idx);
    if (int'(idx) < IN_WIDTH) return x[idx];
    return 1'b0;
  endfunction

  // FSM next-state
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN:  if (last_b) state_d = OUT;
      OUT:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign last_b        = vld_p1 && (nid_p1 == LAST_NID);
  assign cfg_en        = bus.cfg_we && (state_q == IDLE);
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = res_q;
  assign busy          = (state_q == RUN) || (state_q == OUT);

  // Stage A (p0): gather the neuron's FAN_IN selected input bits into a table address
  always_comb begin
    addr_p0 = '0;
    for (int j = 0; j < FAN_IN; j++) begin
      addr_p0[j] = pick_bit(x_reg, conn_mem[nid][j]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      run_a   <= 1'b0;
      nid     <= '0;
      vld_p1  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_p1  <= run_a;
      if (accept) begin
        run_a <= 1'b1;
        nid   <= '0;
        res_q <= '0;
      end else if (run_a) begin
        if (nid == LAST_NID) run_a <= 1'b0;
        else                 nid   <= nid + 1'b1;
      end
      // Stage B (p1): table lookup retires one neuron per cycle
      if (vld_p1) res_q[nid_p1] <= tbl_mem[nid_p1][addr_p1];
    end
  end

  // Stage A -> B pipeline data and the latched input vector
  always_ff @(posedge clk) begin
    if (accept) x_reg <= bus.in_data;
    if (run_a) begin
      addr_p1 <= addr_p0;
      nid_p1  <= nid;
    end
  end

  // Config RAMs are never reset; writes land before RUN reads them.
  always_ff @(posedge clk) begin
    if (cfg_en && (int'(bus.cfg_nid) < N_NEURONS)) begin
      if (!bus.cfg_sel) begin
        tbl_mem[bus.cfg_nid][bus.cfg_addr] <= bus.cfg_data[0];
      end else if (int'(bus.cfg_addr) < FAN_IN) begin
        conn_mem[bus.cfg_nid][bus.cfg_addr[SLOT_W-1:0]] <= bus.cfg_data;
      end
    end
  end

`ifdef LUT_LAYER_SEQUENCER_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  perf_vectors <= '0;
    else if (bus.out_valid && bus.out_ready) perf_vectors <= sat_inc(perf_vectors);
  end
`endif

endmodule
